// File: rtl/rf_dump_reader.sv
// Streams register-file contents R0..NUM_REGS-1 to a valid/ready sink while stalling the core.
// Optional XOR checksum trailer word: define RF_DUMP_CHECKSUM_EN.
module rf_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cpu_stall,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
`ifdef RF_DUMP_CHECKSUM_EN
    ST_CSUM = 3'd4,
`endif
    ST_DONE = 3'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
`ifdef RF_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  logic accept;
  assign accept = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
`ifdef RF_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
`ifdef RF_DUMP_CHECKSUM_EN
        csum_d = '0;
`endif
        if (start) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // rd_data is combinational for rd_addr == idx_q, so capture it now.
        out_data_d  = rd_data;
        out_idx_d   = idx_q;
`ifdef RF_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (accept) begin
          out_valid_d = 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef RF_DUMP_CHECKSUM_EN
            // Trailer word carries the XOR of every register word, including this one.
            state_d     = ST_CSUM;
            out_data_d  = csum_q ^ out_data_q;
            out_idx_d   = '0;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
`else
            state_d = ST_DONE;
`endif
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_LOAD;
          end
        end
      end

`ifdef RF_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          out_valid_d = 1'b0;
          state_d     = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        idx_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
`ifdef RF_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign rd_addr   = idx_q;
  assign busy      = (state_q != ST_IDLE);
  assign cpu_stall = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader: table-driven dumps, corner sequences, random traffic.
module tb_rf_dump_reader;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
`ifdef RF_DUMP_CHECKSUM_EN
  localparam int NWORDS = NUM_REGS + 1;
`else
  localparam int NWORDS = NUM_REGS;
`endif
  localparam int BUSY_FULL = 2 * NUM_REGS + 1 + (NWORDS - NUM_REGS);

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              cpu_stall;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;
  logic              done;

  logic [DATA_W-1:0] rf_mem [NUM_REGS];
  assign rd_data = rf_mem[rd_addr];

  always #5 clock = ~clock;

  rf_dump_reader #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cpu_stall(cpu_stall), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .done(done)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    int                idx;
    logic              last;
  } word_t;

  typedef struct {
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    int                              exp_busy;
    int                              exp_words;
    logic [DATA_W-1:0]               exp_xor;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: a dump is the list of expected words plus a busy/done flag.
  word_t exp_q[$];
  bit    mon_en = 0;
  bit    m_busy = 0;
  bit    m_done = 0;
  int    busy_total = 0;
  int    words_total = 0;
  int    done_total = 0;
  int    dump_ord = 0;
  logic [DATA_W-1:0] rx_xor = '0;
  logic [DATA_W-1:0] last_data = '0;
  int    last_idx = 0;
  logic  last_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_start();
    logic [DATA_W-1:0] x;
    word_t w;
    x = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w.data = rf_mem[i];
      w.idx  = i;
`ifdef RF_DUMP_CHECKSUM_EN
      w.last = 1'b0;
`else
      w.last = (i == NUM_REGS - 1);
`endif
      x = x ^ rf_mem[i];
      exp_q.push_back(w);
    end
`ifdef RF_DUMP_CHECKSUM_EN
    w.data = x;
    w.idx  = 0;
    w.last = 1'b1;
    exp_q.push_back(w);
`endif
  endtask

  task automatic sample_and_model();
    check("stall_eq_busy", 32'(cpu_stall), 32'(busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    if (busy) busy_total++;
    if (done) done_total++;
    if (out_valid) begin
      if (!m_busy || exp_q.size() == 0) begin
        check("unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        check("word_data", 32'(out_data), 32'(exp_q[0].data));
        check("word_idx", 32'(out_idx), 32'(exp_q[0].idx));
        check("word_last", 32'(out_last), 32'(exp_q[0].last));
      end
    end
    if (reset) begin
      m_busy = 0;
      m_done = 0;
      exp_q.delete();
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy   = 1;
        dump_ord = 0;
        rx_xor   = '0;
        model_start();
      end
    end else if (out_valid && out_ready && exp_q.size() > 0) begin
      words_total++;
      if (dump_ord < NUM_REGS) rx_xor = rx_xor ^ out_data;
      dump_ord++;
      last_data = out_data;
      last_idx  = int'(out_idx);
      last_last = out_last;
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_done = 1;
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (mon_en) sample_and_model();
    @(posedge clock);
    #1;
  endtask

  task automatic load_basic();
    for (int i = 0; i < NUM_REGS; i++)
      rf_mem[i] = (i == 0) ? 16'h8000 : 16'(1 << (i - 1));
  endtask

  task automatic run_dump(input bit rnd_ready, output int busy_cycles, output int words,
                          output int dones);
    int b0, w0, d0, n;
    b0 = busy_total; w0 = words_total; d0 = done_total;
    start = 1'b1;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done_total == d0 && n < 400) begin
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      n++;
    end
    check("dump_finished_in_time", 32'(n < 400), 32'd1);
    out_ready = 1'b1;
    step();
    step();
    busy_cycles = busy_total - b0;
    words = words_total - w0;
    dones = done_total - d0;
  endtask

  vec_t vecs[4];

  initial begin
    int bc, wc, dc, n, d0, w0;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = '0;

    for (int i = 0; i < NUM_REGS; i++) begin
      vecs[0].regs[i] = (i == 0) ? 16'h8000 : 16'(1 << (i - 1));
      vecs[1].regs[i] = 16'h0000;
      vecs[2].regs[i] = 16'hFFFF;
      vecs[3].regs[i] = 16'h1111 * 16'(i + 1);
    end
    vecs[0].exp_xor = 16'h807F;
    vecs[1].exp_xor = 16'h0000;
    vecs[2].exp_xor = 16'h0000;
    vecs[3].exp_xor = 16'h8888;
    for (int v = 0; v < 4; v++) begin
      vecs[v].exp_busy  = BUSY_FULL;
      vecs[v].exp_words = NWORDS;
    end

    @(posedge clock);
    #1;
    mon_en = 1;
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    step();
    step();

    // Table-driven full-throughput dumps
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = vecs[v].regs[i];
      run_dump(1'b0, bc, wc, dc);
      $display("vec %0d: busy=%0d words=%0d dones=%0d xor=%04h", v, bc, wc, dc, rx_xor);
      check("vec_busy_cycles", 32'(bc), 32'(vecs[v].exp_busy));
      check("vec_words", 32'(wc), 32'(vecs[v].exp_words));
      check("vec_dones", 32'(dc), 32'd1);
      check("vec_reg_xor", 32'(rx_xor), 32'(vecs[v].exp_xor));
`ifdef RF_DUMP_CHECKSUM_EN
      check("vec_csum_data", 32'(last_data), 32'(vecs[v].exp_xor));
      check("vec_csum_idx", 32'(last_idx), 32'd0);
      check("vec_csum_last", 32'(last_last), 32'd1);
`else
      check("vec_last_idx", 32'(last_idx), 32'(NUM_REGS - 1));
      check("vec_last_flag", 32'(last_last), 32'd1);
`endif
    end

    // Backpressure on word 3
    load_basic();
    w0 = words_total;
    d0 = done_total;
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 3) && n < 100) begin
      step();
      n++;
    end
    check("bp_reached_idx3", 32'(n < 100), 32'd1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      $display("bp cycle %0d: valid=%0d idx=%0d data=%04h", c, out_valid, out_idx, out_data);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_data_held", 32'(out_data), 32'h0004);
      check("bp_idx_held", 32'(out_idx), 32'd3);
    end
    out_ready = 1'b1;
    n = 0;
    while (done_total == d0 && n < 100) begin
      step();
      n++;
    end
    step();
    check("bp_words", 32'(words_total - w0), 32'(NWORDS));
    check("bp_dones", 32'(done_total - d0), 32'd1);

    // Start pulsed while busy at word 2
    w0 = words_total;
    d0 = done_total;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 2) && n < 100) begin
      step();
      n++;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done_total == d0 && n < 100) begin
      step();
      n++;
    end
    for (int c = 0; c < 4; c++) step();
    $display("start-while-busy: words=%0d dones=%0d busy=%0d", words_total - w0, done_total - d0, busy);
    check("swb_words", 32'(words_total - w0), 32'(NWORDS));
    check("swb_dones", 32'(done_total - d0), 32'd1);
    check("swb_idle_after", 32'(busy), 32'd0);

    // Reset while SEND holds word 5
    d0 = done_total;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 5) && n < 100) begin
      step();
      n++;
    end
    check("rmd_reached_idx5", 32'(n < 100), 32'd1);
    out_ready = 1'b0;
    reset = 1'b1;
    step();
    $display("reset mid-dump: valid=%0d busy=%0d rd_addr=%0d done=%0d", out_valid, busy, rd_addr, done);
    check("rmd_out_valid", 32'(out_valid), 32'd0);
    check("rmd_busy", 32'(busy), 32'd0);
    check("rmd_rd_addr", 32'(rd_addr), 32'd0);
    check("rmd_out_data", 32'(out_data), 32'd0);
    check("rmd_out_last", 32'(out_last), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("rmd_no_done", 32'(done_total - d0), 32'd0);
    run_dump(1'b0, bc, wc, dc);
    check("rmd_redump_words", 32'(wc), 32'(NWORDS));
    check("rmd_redump_dones", 32'(dc), 32'd1);

    // Start held high: back-to-back dumps
    d0 = done_total;
    start = 1'b1;
    n = 0;
    while (done_total < d0 + 2 && n < 200) begin
      step();
      n++;
    end
    start = 1'b0;
    check("held_start_two_dumps", 32'(done_total - d0), 32'd2);
    for (int c = 0; c < 2 * BUSY_FULL + 4; c++) step();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (!busy && !start) begin
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = 16'($urandom);
      end
      start = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    step();
    $display("random phase: words=%0d dones=%0d", words_total, done_total);
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
- Read-side sequencer for the 8x16 processor register file.
- On a single start pulse, it walks the file's read-address port through R0..R7, registers each value, and streams the words out over a valid/ready interface.
- The stream feeds a debug/trace sink.
- While it runs, it holds the multi-cycle core stalled so register contents stay stable during the dump.

Parameters:
NUM_REGS, 8, number of registers dumped (indices 0..NUM_REGS-1)
DATA_W, 16, register/data word width
ADDR_W, 3, register index width; NUM_REGS must be <= 2**ADDR_W

Ports:
clock  input  1  clock; all state updates on posedge
reset  input  1  reset, synchronous, active-high
start  input  1  request a dump; sampled only in IDLE
rd_addr  output  ADDR_W  register-file read address (drives Read1/Read2 of the file)
rd_data  input  DATA_W  combinational read data returned for rd_addr
cpu_stall  output  1  high while busy; core must not assert RegWrite or advance
busy  output  1  high in any state other than IDLE
out_valid  output  1  out_data/out_idx/out_last valid
out_ready  input  1  sink accepts the word when out_valid && out_ready
out_data  output  DATA_W  registered register value
out_idx  output  ADDR_W  index of the register in out_data
out_last  output  1  marks the final word of the dump
done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset state:
  - FSM = IDLE.
  - rd_addr = 0, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0.
  - done = 0, busy = 0, cpu_stall = 0.
  - Internal index idx = 0.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - start = 1 -> LOAD, with idx = 0.
  - start = 0 -> stay in IDLE.
- LOAD (exactly one cycle):
  - rd_addr = idx.
  - At the clock edge: out_data <= rd_data, out_idx <= idx, out_last <= (idx == NUM_REGS-1), out_valid <= 1.
  - Next state -> SEND.
- SEND:
  - out_data, out_idx and out_last stay stable until the handshake completes. Any number of out_ready-low cycles is permitted.
  - On out_valid && out_ready:
    - out_valid <= 0.
    - If idx == NUM_REGS-1 -> DONE.
    - Otherwise idx <= idx+1 -> LOAD.
- DONE (one cycle):
  - done = 1 for this cycle, then -> IDLE.
  - idx resets to 0.
- Outputs:
  - busy = cpu_stall = (state != IDLE), registered from state, so it is high the cycle after start is sampled.
  - rd_addr holds the current idx in every state.
- Latency and throughput:
  - start sampled at edge N -> LOAD in cycle N+1 -> out_valid high from edge N+2.
  - With out_ready held at 1: one word per 2 cycles; a full dump takes 2*NUM_REGS+1 cycles from the first LOAD to the end of the done pulse.
- Boundary conditions:
  - start while busy: ignored; no restart, no queuing.
  - start held high continuously: a new dump begins on the cycle after DONE (IDLE samples it).
  - out_ready high while out_valid is low: no effect.
  - Reset mid-dump (any state): takes effect at the next edge. All outputs return to reset values, the partial stream is abandoned, and no done pulse is produced.
  - idx never exceeds NUM_REGS-1; no wrap-around is needed.
- The block never writes the register file.

Optional Feature:
- Macro: RF_DUMP_CHECKSUM_EN.
- Defined:
  - Adds a running DATA_W XOR accumulator, cleared in IDLE and updated with each accepted word.
  - After the register word at NUM_REGS-1 is accepted, the FSM enters an extra CSUM state instead of DONE.
  - In CSUM: out_data = accumulator, out_idx = 0, out_last = 1, out_valid = 1 under the same hold rules. Its acceptance leads to DONE.
  - out_last is 0 on all register words.
  - A dump produces NUM_REGS+1 words.
- Not defined:
  - No accumulator and no CSUM state.
  - out_last is asserted on the word at NUM_REGS-1.

Test Plan:
- Basic dump:
  - Stimulus: RF model R0..R7 = 0x8000, 0x0001, 0x0002, 0x0004, 0x0008, 0x0010, 0x0020, 0x0040; out_ready = 1; pulse start.
  - Required: 8 words in order, out_idx = 0..7 matching the values, out_last only with idx 7, done one cycle later, busy high for 17 cycles.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles on word idx 3.
  - Required: out_data stays 0x0004, out_idx stays 3, out_valid stays 1 throughout; the stream resumes unchanged once ready rises.
- Start while busy:
  - Stimulus: pulse start again during idx 2.
  - Required: no restart; exactly 8 words and one done pulse.
- Reset mid-dump:
  - Stimulus: assert reset while in SEND with idx 5.
  - Required: next cycle out_valid = 0, busy = 0, rd_addr = 0, no done pulse; a new start then dumps from idx 0.
- Stall coverage:
  - Check: cpu_stall equals busy on every cycle; cpu_stall = 0 in IDLE after reset.
- Checksum (RF_DUMP_CHECKSUM_EN):
  - Stimulus: same data as the basic dump.
  - Required: 9th word is 0x807F with out_idx 0 and out_last 1; out_last is 0 on words 0..7.
